// File: rtl/ex_sequencer.sv
// ex_sequencer: multicycle control FSM for the MIPS core's EX stage.
// It sequences the shared instruction/data memory port and register writeback.
//
// Ports:
//   CLK, RST          rising-edge clock; synchronous active-high reset
//   Ins[31:0]         instruction register (only the opcode, Ins[31:26], is used)
//   MemReady          memory completes the current access this cycle
//   BrTaken           branch condition from EX
//   IREn, PCWr        instruction-register load and PC write strobes
//   PCSrc[1:0]        0 = PC+4, 1 = branch target, 2 = jump target
//   EXEn              EX stage enable
//   MemRd, MemWr      memory read and write requests
//   RegWr, MemToReg   register write and writeback source select
//   State[2:0]        current state encoding
//   Trap, TrapCause   halted flag; cause 01 = illegal opcode, 10 = memory timeout
//   InstRet[31:0]     retired-instruction count (only with EX_SEQ_PERF_CNT_EN)
//
// Strobes are combinational from the state and inputs, and are forced to 0
// during any cycle with RST=1. Only the state, the wait counter, the trap cause
// and the optional retire counter are registered.
// Optional feature: define EX_SEQ_PERF_CNT_EN to add the InstRet counter.
module ex_sequencer #(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned CNT_W        = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] Ins,
  input  logic        MemReady,
  input  logic        BrTaken,
  output logic        IREn,
  output logic        PCWr,
  output logic [1:0]  PCSrc,
  output logic        EXEn,
  output logic        MemRd,
  output logic        MemWr,
  output logic        RegWr,
  output logic        MemToReg,
  output logic [2:0]  State,
  output logic        Trap,
`ifdef EX_SEQ_PERF_CNT_EN
  output logic [1:0]  TrapCause,
  output logic [31:0] InstRet
`else
  output logic [1:0]  TrapCause
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MEM_WAIT_MAX);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       cause_q, cause_d;
  logic [5:0]       opcode;
  logic             waiting_c;
  logic             retire_c;

  logic             ire_c, pcwr_c, exen_c, memrd_c, memwr_c, regwr_c, m2r_c, trap_c;
  logic [1:0]       pcsrc_c;

  // Bits below the opcode field carry no control information.
  logic             unused_ins;
  assign unused_ins = ^Ins[25:0];

  assign opcode = Ins[31:26];

  // State, wait counter and trap-cause registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (waiting_c && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    waiting_c = 1'b0;
    ire_c     = 1'b0;
    pcwr_c    = 1'b0;
    pcsrc_c   = 2'd0;
    exen_c    = 1'b0;
    memrd_c   = 1'b0;
    memwr_c   = 1'b0;
    regwr_c   = 1'b0;
    m2r_c     = 1'b0;
    trap_c    = 1'b0;

    case (state_q)
      S_FETCH: begin
        memrd_c = 1'b1;
        if (MemReady) begin
          ire_c   = 1'b1;
          pcwr_c  = 1'b1;
          pcsrc_c = 2'd0;
          state_d = S_DECODE;
        end else begin
          waiting_c = 1'b1;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        exen_c = 1'b1;
        case (opcode)
          OP_RTYPE, OP_ADDI, OP_ADDIU, OP_SLTI,
          OP_ANDI, OP_ORI, OP_XORI, OP_LUI: state_d = S_WB;
          OP_BEQ, OP_BNE: begin
            if (BrTaken) begin
              pcwr_c  = 1'b1;
              pcsrc_c = 2'd1;
            end
            state_d = S_FETCH;
          end
          OP_J: begin
            pcwr_c  = 1'b1;
            pcsrc_c = 2'd2;
            state_d = S_FETCH;
          end
          OP_LW, OP_SW: state_d = S_MEM;
          default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEM: begin
        // Only LW or SW reach this state, and Ins is held stable.
        if (opcode == OP_LW) memrd_c = 1'b1;
        else                 memwr_c = 1'b1;
        if (MemReady) begin
          state_d = (opcode == OP_LW) ? S_WB : S_FETCH;
        end else begin
          waiting_c = 1'b1;
        end
      end
      S_WB: begin
        regwr_c = 1'b1;
        m2r_c   = (opcode == OP_LW);
        state_d = S_FETCH;
      end
      S_TRAP: trap_c = 1'b1;
      default: begin
        state_d = S_TRAP;
        cause_d = CAUSE_ILLEGAL;
      end
    endcase

    // A memory wait at the limit with no ready traps; a ready in that cycle wins.
    if (waiting_c && (cnt_q == WAIT_LIM)) begin
      state_d = S_TRAP;
      cause_d = CAUSE_TIMEOUT;
    end
  end

  assign retire_c = (state_q == S_WB) ||
                    (((state_q == S_EXEC) || (state_q == S_MEM)) && (state_d == S_FETCH));

  // During reset every output reads 0, including any aborted strobe.
  assign IREn      = ~RST & ire_c;
  assign PCWr      = ~RST & pcwr_c;
  assign PCSrc     = RST ? 2'd0 : pcsrc_c;
  assign EXEn      = ~RST & exen_c;
  assign MemRd     = ~RST & memrd_c;
  assign MemWr     = ~RST & memwr_c;
  assign RegWr     = ~RST & regwr_c;
  assign MemToReg  = ~RST & m2r_c;
  assign State     = RST ? 3'd0 : 3'(state_q);
  assign Trap      = ~RST & trap_c;
  assign TrapCause = RST ? 2'd0 : cause_q;

`ifdef EX_SEQ_PERF_CNT_EN
  logic [31:0] inst_ret_q;

  // Retired-instruction counter; wraps and never advances in TRAP.
  always_ff @(posedge CLK) begin
    if (RST)           inst_ret_q <= '0;
    else if (retire_c) inst_ret_q <= inst_ret_q + 32'd1;
  end

  assign InstRet = RST ? 32'd0 : inst_ret_q;
`else
  logic unused_retire;
  assign unused_retire = retire_c;
`endif

endmodule

// File: doc/ex_sequencer.md
Name: ex_sequencer

Overview:
Multicycle control FSM that sequences the EX stage, the shared instruction/data memory port, and register writeback for the MIPS core.
- Fetches and latches an instruction, then enables EX.
- Resolves branches and jumps from EX outputs.
- Issues load/store accesses with a ready handshake.
- Asserts register write.
- Traps on illegal opcodes or memory timeouts.

Parameters:
MEM_WAIT_MAX, 15, maximum cycles in a memory wait before timeout trap (1..255)
CNT_W, 8, width of wait counter

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous active-high reset
Ins  in  32  instruction register contents (valid from DECODE onward)
MemReady  in  1  memory completes current access this cycle
BrTaken  in  1  from EX: branch condition true (BEQ equal / BNE unequal)
IREn  out  1  load instruction register
PCWr  out  1  write PC
PCSrc  out  2  0=nextPC (PC+4), 1=newPC (branch target), 2=jump target
EXEn  out  1  EX stage enable (latch Result/newPC)
MemRd  out  1  memory read request
MemWr  out  1  memory write request
RegWr  out  1  register file write
MemToReg  out  1  writeback source: 1=memory data, 0=Result
State  out  3  current state encoding
Trap  out  1  sequencer halted
TrapCause  out  2  01=illegal opcode, 10=memory timeout

Behaviour:
- Reset: state=FETCH, wait counter=0, Trap=0, TrapCause=0.
  - All outputs are 0 during any cycle with RST=1.
  - Reset mid-instruction aborts without issuing PCWr/RegWr/MemWr.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Codes 6/7 go to TRAP with cause 01.
- FETCH:
  - MemRd=1.
  - If MemReady: IREn=1, PCWr=1, PCSrc=0, go to DECODE.
  - Else stay.
- DECODE: no strobes; 1 cycle; go to EXEC.
- EXEC: EXEn=1. Opcode = Ins[31:26].
  - 0x00 R-type, or 0x08,0x09,0x0A,0x0C,0x0D,0x0E,0x0F: go to WB.
  - 0x04 BEQ / 0x05 BNE:
    - If BrTaken: PCWr=1, PCSrc=1.
    - Go to FETCH either way.
  - 0x02 J: PCWr=1, PCSrc=2, go to FETCH.
  - 0x23 LW / 0x2B SW: go to MEM.
  - Any other opcode: go to TRAP, TrapCause=01.
- MEM:
  - LW: MemRd=1. SW: MemWr=1.
  - On MemReady: LW goes to WB, SW goes to FETCH.
  - Else stay.
- WB:
  - RegWr=1, MemToReg=1 iff opcode 0x23.
  - 1 cycle; go to FETCH.
- TRAP: all strobes 0, Trap=1; holds until RST.
- Strobe timing:
  - Outputs are combinational from State, Ins, MemReady and BrTaken (Mealy in FETCH/MEM/EXEC).
  - State and counter are registered.
- Wait counter:
  - Clears on every state change.
  - Increments each FETCH/MEM cycle with MemReady=0, saturating at 2^CNT_W-1.
  - If the counter equals MEM_WAIT_MAX and MemReady=0: next state TRAP, TrapCause=10.
  - MemReady in the same cycle the counter reaches MEM_WAIT_MAX wins; no trap.
- Latency (MemReady always 1): R/I-type 4 cycles, LW 5, SW 4, branch/J 3.
- Instruction bits outside [31:26] are ignored; Ins must be stable from DECODE to instruction end.

Optional Feature:
Macro EX_SEQ_PERF_CNT_EN.
- Defined: adds output InstRet (32 bits).
  - Counts completed instructions: +1 on transition out of WB, out of EXEC to FETCH, or out of MEM to FETCH.
  - Wraps at 2^32, resets to 0, frozen in TRAP.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- BEQ taken: Ins={6'h04,26'd0}, BrTaken=1, MemReady=1 -> states 0,1,2,0. In EXEC: PCWr=1, PCSrc=1, EXEn=1. Instruction done 3 cycles after reset release.
- BEQ not taken: BrTaken=0 -> EXEC has PCWr=0. BNE {6'h05,...} with BrTaken=1 -> PCWr=1, PCSrc=1.
- LW with MemReady low 3 cycles in MEM: Ins={6'h23,...} -> MemRd=1 for 4 MEM cycles, then WB with RegWr=1, MemToReg=1. SW {6'h2B,...} -> MemWr=1, no RegWr, back to FETCH.
- Illegal opcode 6'h3F -> TRAP after EXEC, Trap=1, TrapCause=01. No PCWr/RegWr afterwards; RST=1 for 1 cycle returns to FETCH with MemRd=1.
- Timeout: MemReady held 0 in FETCH -> TRAP, TrapCause=10, entered after exactly MEM_WAIT_MAX+1 FETCH cycles (16 at default). MemReady=1 on the 16th cycle -> no trap, IREn=1.
- Reset mid-MEM of SW: RST=1 -> MemWr=0 that cycle, State=0 next. With EX_SEQ_PERF_CNT_EN, InstRet=0; after three ADDI (6'h08) instructions, InstRet=3.
